// File: rtl/alu_seq_pkg.sv
// Shared definitions for the sequenced ALU: default width, control word layout,
// shift encoding and controller states.
package alu_seq_pkg;

  localparam int NBITS       = 16;
  localparam int ALU_CONTROL = 6;

  // bit 5 = f0 ... bit 0 = inc
  typedef struct packed {
    logic f0;
    logic f1;
    logic ena;
    logic enb;
    logic inva;
    logic inc;
  } alu_ctrl_t;

  typedef enum logic [1:0] {
    SH_NONE     = 2'b00,
    SH_SRA1     = 2'b01,
    SH_SLL8     = 2'b10,
    SH_NONE_ALT = 2'b11
  } shift_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/alu_seq_core.sv
// Combinational ALU slice: operand gating, optional A inversion, then the
// four-function select. Carry out of the add is dropped.
module alu_core
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = NBITS
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  alu_ctrl_t        ctrl,
  output logic [WIDTH-1:0] result
);

  logic [WIDTH-1:0] a_gated;
  logic [WIDTH-1:0] b_gated;
  logic [WIDTH-1:0] a_op;

  always_comb begin
    a_gated = ctrl.ena ? a : '0;
    b_gated = ctrl.enb ? b : '0;
    // inversion sees the gated operand, so ENA=0 with INVA=1 yields all ones
    a_op    = ctrl.inva ? ~a_gated : a_gated;
    unique case ({ctrl.f0, ctrl.f1})
      2'b00:   result = a_op & b_gated;
      2'b01:   result = a_op | b_gated;
      2'b10:   result = ~b_gated;
      default: result = a_op + b_gated + {{(WIDTH-1){1'b0}}, ctrl.inc};
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// Sequenced ALU with valid/ready handshake, iterative shift-add multiplier and
// a post-result shifter. Results and flags are registered.
//
//   state   | meaning
//   IDLE    | no result held, ready for a command
//   MUL     | shift-add multiply in progress, one multiplier bit per cycle
//   DONE    | result presented on y/n/z until out_ready
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH  = NBITS,
  parameter bit MUL_EN = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       a,
  input  logic [WIDTH-1:0]       b,
  input  logic [ALU_CONTROL-1:0] ctrl,
  input  logic [1:0]             shift,
  input  logic                   mul,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       y,
  output logic                   n,
  output logic                   z
);

  localparam int CW = $clog2(WIDTH + 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] mcand_q, mplier_q, acc_q;
  shift_e           shift_q;

  logic             accept, mul_cmd, last_iter;
  logic [WIDTH-1:0] alu_result, prod_next;

  function automatic logic [WIDTH-1:0] apply_shift(input logic [WIDTH-1:0] r,
                                                   input shift_e s);
    case (s)
      SH_SRA1: return {r[WIDTH-1], r[WIDTH-1:1]};
      SH_SLL8: return {r[WIDTH-9:0], 8'h00};
      default: return r;
    endcase
  endfunction

  alu_core #(.WIDTH(WIDTH)) u_core (
    .a      (a),
    .b      (b),
    .ctrl   (alu_ctrl_t'(ctrl)),
    .result (alu_result)
  );

  assign mul_cmd   = MUL_EN && mul;
  assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == ST_DONE);
  assign last_iter = (cnt_q == CW'(WIDTH - 1));
  assign prod_next = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept) state_d = mul_cmd ? ST_MUL : ST_DONE;
      ST_MUL:  if (last_iter) state_d = ST_DONE;
      ST_DONE: begin
        if (accept)         state_d = mul_cmd ? ST_MUL : ST_DONE;
        else if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // non-multiply results are produced straight from the accepted inputs so
  // they appear the cycle after accept; the multiplier works from its own copies
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      shift_q  <= SH_NONE;
      y        <= '0;
      n        <= 1'b0;
      z        <= 1'b0;
    end else if (accept) begin
      mcand_q  <= a;
      mplier_q <= b;
      acc_q    <= '0;
      cnt_q    <= '0;
      shift_q  <= shift_e'(shift);
      if (!mul_cmd) begin
        y <= apply_shift(alu_result, shift_e'(shift));
        n <= alu_result[WIDTH-1];
        z <= (alu_result == '0);
      end
    end else if (state_q == ST_MUL) begin
      acc_q    <= prod_next;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + CW'(1);
      if (last_iter) begin
        y <= apply_shift(prod_next, shift_q);
        n <= prod_next[WIDTH-1];
        z <= (prod_next == '0);
      end
    end
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default NBITS, datapath width in bits; SHALL be >= 9.
REQ-002 Parameter MUL_EN, default 1, enables the iterative multiply mode (0: the mul input is ignored and treated as 0).
REQ-003 Clocking: one clock, clk; reset rst_n is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  operand/command valid.
REQ-007 in_ready  output  1  block can accept a command this cycle.
REQ-008 a, b  input  WIDTH  operands.
REQ-009 ctrl  input  ALU_CONTROL (6)  {F0,F1,ENA,ENB,INVA,INC}, bit 5 = F0.
REQ-010 shift  input  2  post-ALU shift: 00 none, 01 SRA1, 10 SLL8, 11 none.
REQ-011 mul  input  1  1 = unsigned multiply a*b; ctrl is ignored.
REQ-012 out_valid  output  1  result valid.
REQ-013 out_ready  input  1  consumer accepts the result.
REQ-014 y  output  WIDTH  shifted result.
REQ-015 n, z  output  1  sign and zero flags of the pre-shift result.

Function
REQ-016 Operand gating: A' = ENA ? a : 0, B' = ENB ? b : 0, then A'' = INVA ? ~A' : A'; gating is applied before inversion.
REQ-017 F0F1 decoding: 00 A''&B', 01 A''|B', 10 ~B', 11 A''+B'+INC; INC affects only the add; carry-out is discarded and the result wraps modulo 2^WIDTH.
REQ-018 Multiply: shift-add over WIDTH iterations (one multiplier bit per cycle); only the low WIDTH product bits are kept.
REQ-019 Shift is applied after the ALU/multiply result: SRA1 = arithmetic right shift by 1, SLL8 = logical left shift by 8 with zero fill.
REQ-020 n = MSB of the pre-shift result; z = 1 if and only if the pre-shift result equals 0.
REQ-021 FSM states and transitions: IDLE -> (accept, mul=0) DONE; IDLE -> (accept, mul=1) MUL; MUL -> (counter = WIDTH-1) DONE; DONE -> (out_ready, no new accept) IDLE; DONE -> (out_ready and accept) DONE or MUL.
REQ-022 Accept condition: in_valid && in_ready; in_ready = (state==IDLE) || (state==DONE && out_ready); in_ready is 0 in MUL.
REQ-023 Latency: for a non-multiply command, out_valid is asserted on the cycle after accept; for multiply, out_valid is asserted WIDTH+1 cycles after accept.
REQ-024 The block SHALL register a, b, ctrl, shift and mul on accept; later input changes SHALL NOT affect an operation in flight.
REQ-025 out_valid = (state==DONE); y, n and z SHALL hold stable while out_valid && !out_ready.
REQ-026 Back-to-back: a result is consumed and a new command accepted in the same cycle; no bubble for non-multiply commands.
REQ-027 y, n and z SHALL be registered outputs; no combinational path from a, b or ctrl to y.

Reset
REQ-028 On rst_n low (asynchronous): state = IDLE, out_valid = 0, y = 0, n = 0, z = 0, the iteration counter and internal registers are cleared; in_ready = 1 after release.
REQ-029 Reset during MUL or DONE aborts the operation; the result is discarded and never presented.

Structure
REQ-030 The shared definitions package SHALL hold NBITS, ALU_CONTROL, the shift encoding enum and the FSM state enum.
REQ-031 A purely combinational sub-module alu_core (a, b, ctrl -> result) implements REQ-016/017; alu_seq instantiates it once and adds the FSM, multiplier, shifter and registers.
REQ-032 The iteration counter SHALL be $clog2(WIDTH+1) bits wide.

Verification (WIDTH=16)
REQ-033 a=CDCD, b=ABAB, ctrl=3C, shift=00 -> y=7978, n=0, z=0, out_valid one cycle after accept.
REQ-034 Same a and b, ctrl=3F, then again with shift=01 -> y=DDDE with n=1, then y=EEEF with n=1.
REQ-035 ctrl=10 -> y=0000, z=1; ctrl=32 -> y=FFFF, n=1; ctrl=18, shift=10, a=CDCD -> y=CD00, n=1.
REQ-036 mul=1, a=0003, b=0005 -> y=000F after 17 cycles, in_ready=0 throughout; a=b=FFFF -> y=0001.
REQ-037 out_ready held low for 5 cycles in DONE -> y stable, in_ready=0; then out_ready=1 with in_valid=1 -> new command accepted in the same cycle.
REQ-038 rst_n pulsed low at multiply cycle 7 -> out_valid=0 immediately, that result is never presented, in_ready=1 after release.
